alu_regfile_sequencer: RTL

Operand-fetch and writeback stage that sits directly upstream of top_level_alu and also consumes its results. Holds an 8-entry x 8-bit register file and accepts register-to-register commands (func, rs1, rs2, rd) over a valid/ready handshake. For each command it drives reg1/reg2/func into the ALU, waits the ALU's registered latency, then writes alu_out back to rd and latches carry_out.

---
 rtl/alu_regfile_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_regfile_sequencer.sv
// Operand-fetch/writeback sequencer for an external ALU; 8x8 register file with direct load port.
// Latency: accept E0, fetch E1, writeback E1+ALU_LAT, done pulses the cycle after; cmd_ready low while busy.
// Backpressure: one command in flight, cmd_valid ignored (not queued) while cmd_ready is low.
module alu_regfile_sequencer #(
    parameter int DATA_W  = 8,
    parameter int NREG    = 8,
    parameter int ADDR_W  = 3,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_func,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [2:0]        alu_func,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_rf [NREG];
    logic [2:0]        r_func;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_alu_reg1;
    logic [DATA_W-1:0] r_alu_reg2;
    logic [2:0]        r_alu_func;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_done;

    logic w_wb;

    assign w_wb       = (r_state == S_WAIT) && (r_cnt == '0);
    assign cmd_ready  = (r_state == S_IDLE);
    assign alu_reg1   = r_alu_reg1;
    assign alu_reg2   = r_alu_reg2;
    assign alu_func   = r_alu_func;
    assign result     = r_result;
    assign carry_flag = r_carry;
    assign done       = r_done;
    assign dbg_data   = r_rf[dbg_addr];

    // Writeback beats a same-address direct load on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (ld_en && !(w_wb && (ld_addr == r_rd))) begin
                r_rf[ld_addr] <= ld_data;
            end
            if (w_wb) begin
                r_rf[r_rd] <= alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_func     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_alu_reg1 <= '0;
            r_alu_reg2 <= '0;
            r_alu_func <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_func  <= cmd_func;
                        r_rs1   <= cmd_rs1;
                        r_rs2   <= cmd_rs2;
                        r_rd    <= cmd_rd;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Operands see the regfile before any load landing on this edge.
                    r_alu_reg1 <= r_rf[r_rs1];
                    r_alu_reg2 <= r_rf[r_rs2];
                    r_alu_func <= r_func;
                    r_cnt      <= CNT_W'(ALU_LAT - 1);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_result <= alu_out;
                        r_carry  <= alu_carry;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
